// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared control definitions for the multi-cycle controller and the ALU controller:
// FSM states, ALUOp codes, opcode/funct constants, datapath select codes, control bundle.
package multi_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MUL    = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6
  } state_t;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type funct codes, instruction bits [5:0]
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd6;
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_SLT  = 6'd42;

  // ALUOp codes seen by the ALU controller
  localparam logic [3:0] ALUOP_NONE  = 4'b0000;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0001;
  localparam logic [3:0] ALUOP_ADDI  = 4'b0010;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0011;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
  localparam logic [3:0] ALUOP_LUI   = 4'b0101;
  localparam logic [3:0] ALUOP_ORI   = 4'b0110;
  localparam logic [3:0] ALUOP_BNE   = 4'b0111;
  localparam logic [3:0] ALUOP_ADD   = 4'b1000;
  localparam logic [3:0] ALUOP_LW    = 4'b1000;
  localparam logic [3:0] ALUOP_SW    = 4'b1001;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam int MUL_CNT_W = 6;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       mul_busy;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_mult(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && (funct == FN_MULT);
  endfunction

  // Instructions that take the EXEC path (everything decodable except J and MULT)
  function automatic logic is_exec_legal(input logic [5:0] op, input logic [5:0] funct);
    logic legal;
    legal = 1'b0;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_SLTI, OP_BEQ, OP_LUI, OP_ORI, OP_BNE, OP_LW, OP_SW: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

  function automatic logic [3:0] alu_op_for(input logic [5:0] op);
    logic [3:0] code;
    case (op)
      OP_RTYPE: code = ALUOP_RTYPE;
      OP_ADDI:  code = ALUOP_ADDI;
      OP_SLTI:  code = ALUOP_SLTI;
      OP_BEQ:   code = ALUOP_BEQ;
      OP_LUI:   code = ALUOP_LUI;
      OP_ORI:   code = ALUOP_ORI;
      OP_BNE:   code = ALUOP_BNE;
      OP_LW:    code = ALUOP_LW;
      OP_SW:    code = ALUOP_SW;
      default:  code = ALUOP_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_mul_cycle_counter.sv
// Down-counter timing the MULT execute step; load on MUL entry, decrement each MUL cycle.
// Latency: done is combinational from the count; load wins over decrement.
// Backpressure: none; holds at zero until reloaded.
module mul_cycle_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with a fixed-length MULT step.
// Latency: J 2, branch 3, R/imm/SW 4, LW 5, MULT 2+MUL_CYCLES states with zero-wait memory.
// Backpressure: FETCH and MEM hold mem_req_o until mem_ack_i; ack elsewhere is ignored.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_op_o,
  output logic       mul_busy_o,
  output logic       illegal_o
);

  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 1);

  state_t state;
  ctrl_t  ctrl;
  logic   mul_load;
  logic   mul_dec;
  logic   mul_done;
  logic   is_branch;
  logic   is_mem_op;
  logic   branch_taken;

  assign is_branch    = (op_i == OP_BEQ) || (op_i == OP_BNE);
  assign is_mem_op    = (op_i == OP_LW) || (op_i == OP_SW);
  assign branch_taken = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);

  // Loaded with N-1 so that done rises in the N-th MUL cycle
  assign mul_load = (state == ST_DECODE) && is_mult(op_i, funct_i);
  assign mul_dec  = (state == ST_MUL);

  mul_cycle_counter #(
    .W (MUL_CNT_W)
  ) u_mul_cnt (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (mul_load),
    .load_val (MUL_LOAD),
    .dec      (mul_dec),
    .done     (mul_done)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ack_i) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (op_i == OP_J)                     state <= ST_FETCH;
          else if (is_mult(op_i, funct_i))      state <= ST_MUL;
          else if (is_exec_legal(op_i, funct_i)) state <= ST_EXEC;
          else                                  state <= ST_FETCH;
        end
        ST_EXEC: begin
          if (is_branch)      state <= ST_FETCH;
          else if (is_mem_op) state <= ST_MEM;
          else                state <= ST_WB;
        end
        ST_MUL: begin
          if (mul_done) state <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_ack_i) state <= (op_i == OP_LW) ? ST_WB : ST_FETCH;
        end
        ST_WB:   state <= ST_FETCH;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: state only, plus ack in FETCH, zero in EXEC, op/funct where needed
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.ir_write  = mem_ack_i;
        ctrl.pc_write  = mem_ack_i;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        if (op_i == OP_J) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_JUMP;
        end else if (!is_mult(op_i, funct_i) && !is_exec_legal(op_i, funct_i)) begin
          ctrl.illegal = 1'b1;
        end
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ((op_i == OP_RTYPE) || is_branch) ? SRC_B_RT : SRC_B_IMM;
        ctrl.alu_op    = alu_op_for(op_i);
        if (is_branch && branch_taken) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_ALUOUT;
        end
      end
      ST_MUL: begin
        ctrl.alu_op   = ALUOP_RTYPE;
        ctrl.mul_busy = 1'b1;
      end
      ST_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.mem_we  = (op_i == OP_SW);
      end
      ST_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op_i == OP_RTYPE);
        ctrl.mem_to_reg = (op_i == OP_LW);
      end
      default: ctrl = '0;
    endcase
  end

  assign mem_req_o    = ctrl.mem_req;
  assign mem_we_o     = ctrl.mem_we;
  assign iord_o       = ctrl.iord;
  assign ir_write_o   = ctrl.ir_write;
  assign pc_write_o   = ctrl.pc_write;
  assign pc_src_o     = ctrl.pc_src;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign mul_busy_o   = ctrl.mul_busy;
  assign illegal_o    = ctrl.illegal;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: reset, ADD, LW with fetch wait, branches, J,
// illegal opcode, MULT duration and asynchronous reset during MULT.
module tb_multi_cycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ack_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       iord_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic [1:0] pc_src_o;
  logic       reg_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [3:0] alu_op_o;
  logic       mul_busy_o;
  logic       illegal_o;

  logic [19:0] all_outs;
  int checks = 0;
  int failures = 0;
  int excl_viol = 0;
  int busy_cnt;
  int busy_rw;

  multi_cycle_ctrl #(.MUL_CYCLES(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .funct_i      (funct_i),
    .zero_i       (zero_i),
    .mem_ack_i    (mem_ack_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .iord_o       (iord_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .mul_busy_o   (mul_busy_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  assign all_outs = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                     reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                     alu_op_o, mul_busy_o, illegal_o};

  always @(negedge clk_i) begin
    if (pc_write_o && reg_write_o) excl_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 1 unit later
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i = 1'b0; op_i = 6'd0; funct_i = 6'd0; zero_i = 1'b0; mem_ack_i = 1'b1;
    #3;
    chk("reset_outs_zero", 32'(all_outs), 0);
    step();

    // ADD with zero-wait ack: IDLE, FETCH, DECODE, EXEC, WB
    rst_i = 1'b1; op_i = 6'd0; funct_i = 6'd32; settle();
    chk("idle_outs_zero", 32'(all_outs), 0);
    step(); settle();
    chk("add_fetch_req", 32'(mem_req_o), 1);
    chk("add_fetch_irw", 32'(ir_write_o), 1);
    chk("add_fetch_pcw", 32'(pc_write_o), 1);
    chk("add_fetch_srcb", 32'(alu_src_b_o), 1);
    chk("add_fetch_aluop", 32'(alu_op_o), 4'b1000);
    step(); settle();
    chk("add_dec_srcb", 32'(alu_src_b_o), 3);
    chk("add_dec_req", 32'(mem_req_o), 0);
    step(); settle();
    chk("add_exec_aluop", 32'(alu_op_o), 4'b0001);
    chk("add_exec_srca", 32'(alu_src_a_o), 1);
    chk("add_exec_srcb", 32'(alu_src_b_o), 0);
    chk("add_exec_noreg", 32'(reg_write_o), 0);
    step(); settle();
    chk("add_wb_rw", 32'(reg_write_o), 1);
    chk("add_wb_rdst", 32'(reg_dst_o), 1);
    chk("add_wb_m2r", 32'(mem_to_reg_o), 0);

    // LW with the fetch ack delayed by three cycles
    step(); mem_ack_i = 1'b0; op_i = 6'd35; funct_i = 6'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lw_wait_req", 32'(mem_req_o), 1);
      chk("lw_wait_irw", 32'(ir_write_o), 0);
      step();
    end
    mem_ack_i = 1'b1; settle();
    chk("lw_ack_req", 32'(mem_req_o), 1);
    chk("lw_ack_irw", 32'(ir_write_o), 1);
    step(); settle();
    chk("lw_dec_irw", 32'(ir_write_o), 0);
    step(); settle();
    chk("lw_exec_aluop", 32'(alu_op_o), 4'b1000);
    chk("lw_exec_srcb", 32'(alu_src_b_o), 2);
    step(); settle();
    chk("lw_mem_req", 32'(mem_req_o), 1);
    chk("lw_mem_iord", 32'(iord_o), 1);
    chk("lw_mem_we", 32'(mem_we_o), 0);
    step(); settle();
    chk("lw_wb_rw", 32'(reg_write_o), 1);
    chk("lw_wb_m2r", 32'(mem_to_reg_o), 1);
    chk("lw_wb_rdst", 32'(reg_dst_o), 0);

    // BEQ with zero=1 is taken
    step(); op_i = 6'd4; zero_i = 1'b1;
    step(); step(); settle();
    chk("beq_exec_pcw", 32'(pc_write_o), 1);
    chk("beq_exec_pcsrc", 32'(pc_src_o), 1);
    chk("beq_exec_aluop", 32'(alu_op_o), 4'b0100);

    // BNE with zero=1 is not taken; flipping zero in EXEC makes it taken
    step(); op_i = 6'd5;
    step(); step(); settle();
    chk("bne_z1_pcw", 32'(pc_write_o), 0);
    chk("bne_exec_aluop", 32'(alu_op_o), 4'b0111);
    zero_i = 1'b0; settle();
    chk("bne_z0_pcw", 32'(pc_write_o), 1);

    // J: PC write with jump target in DECODE, back to FETCH after 2 states
    step(); op_i = 6'd2;
    step(); settle();
    chk("j_dec_pcw", 32'(pc_write_o), 1);
    chk("j_dec_pcsrc", 32'(pc_src_o), 2);
    step(); settle();
    chk("j_next_fetch", 32'(mem_req_o), 1);

    // Illegal opcode 63
    op_i = 6'd63;
    step(); settle();
    chk("ill_dec_pulse", 32'(illegal_o), 1);
    chk("ill_dec_nowrite", 32'({pc_write_o, reg_write_o, ir_write_o}), 0);
    step(); settle();
    chk("ill_pulse_end", 32'(illegal_o), 0);
    chk("ill_next_fetch", 32'(mem_req_o), 1);

    // MULT: busy for exactly 32 cycles, no register write, then FETCH
    op_i = 6'd0; funct_i = 6'd24;
    step(); step(); settle();
    chk("mul_aluop", 32'(alu_op_o), 4'b0001);
    busy_cnt = 0; busy_rw = 0;
    for (int i = 0; i < 80; i++) begin
      if (!mul_busy_o) break;
      busy_cnt++;
      if (reg_write_o) busy_rw++;
      step(); settle();
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32);
    chk("mul_no_regwrite", 32'(busy_rw), 0);
    chk("mul_then_fetch", 32'(mem_req_o), 1);

    // Reset asserted mid-MULT clears outputs immediately
    step(); step(); step(); step();
    rst_i = 1'b0; settle();
    chk("rst_mid_mul_outs", 32'(all_outs), 0);
    step(); rst_i = 1'b1; settle();
    chk("rst_release_idle", 32'(all_outs), 0);
    step(); settle();
    chk("rst_release_fetch", 32'(mem_req_o), 1);

    chk("pc_reg_exclusive", 32'(excl_viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 32, the number of cycles the MULT execute step occupies (legal range 2..63).
REQ-002 SHALL have ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- op_i  in  6  instruction opcode [31:26], valid while IR holds the instruction
- funct_i  in  6  instruction funct [5:0]
- zero_i  in  1  ALU zero flag
- mem_ack_i  in  1  memory completes the pending request
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  request is a write
- iord_o  out  1  memory address from ALUOut (1) or PC (0)
- ir_write_o  out  1  load IR
- pc_write_o  out  1  load PC
- pc_src_o  out  2  0 ALU result, 1 ALUOut (branch target), 2 jump target
- reg_write_o  out  1  register-file write
- reg_dst_o  out  1  write address is rd (1) or rt (0)
- mem_to_reg_o  out  1  write data from MDR (1) or ALUOut (0)
- alu_src_a_o  out  1  ALU A is rs (1) or PC (0)
- alu_src_b_o  out  2  0 rt, 1 constant 4, 2 sign/zero-ext imm, 3 imm<<2
- alu_op_o  out  4  ALUOp to the ALU controller
- mul_busy_o  out  1  MULT in progress
- illegal_o  out  1  one-cycle pulse on an undecodable instruction

Function
REQ-003 SHALL implement a Moore FSM: IDLE, FETCH, DECODE, EXEC, MUL, MEM, WB; all outputs decode from the state (plus op/funct/zero where stated).
REQ-004 ALUOp encoding SHALL be: R-type 0001, ADDI 0010, SLTI 0011, BEQ 0100, LUI 0101, ORI 0110, BNE 0111, LW 1000, SW 1001; address/PC adds use 1000.
REQ-005 IDLE: all outputs 0; SHALL go to FETCH on the next edge.
REQ-006 FETCH: mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=1000; SHALL stay while mem_ack_i=0; on the ack cycle ir_write_o=1, pc_write_o=1, pc_src_o=0, next DECODE.
REQ-007 DECODE: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=1000 (branch target into ALUOut); J (op 2): pc_write_o=1, pc_src_o=2, next FETCH; op 0 with funct 24 (MULT): next MUL; the legal set (op 0 with funct 32/34/36/37/42/0/6; op 8/10/4/15/13/5/35/43): next EXEC; otherwise illegal_o=1, next FETCH, no writes.
REQ-008 EXEC: alu_src_a_o=1; alu_src_b_o=0 for R/BEQ/BNE, else 2; alu_op_o per REQ-004; BEQ taken iff zero_i=1, BNE taken iff zero_i=0 (taken: pc_write_o=1, pc_src_o=1); branches next FETCH, LW/SW next MEM, others next WB.
REQ-009 MUL: alu_op_o=0001, mul_busy_o=1 for exactly MUL_CYCLES cycles, counted by an internal counter cleared on entry; then FETCH; no register write.
REQ-010 MEM: mem_req_o=1, iord_o=1, mem_we_o=1 for SW; SHALL hold until mem_ack_i; on ack SW next FETCH, LW next WB.
REQ-011 WB: reg_write_o=1 for exactly one cycle; reg_dst_o=1 for R-type only; mem_to_reg_o=1 for LW only; next FETCH.
REQ-012 Latency with zero-wait ack SHALL be: J 2, BEQ/BNE 3, R/imm/SW 4, LW 5, MULT 2+MUL_CYCLES cycles.
REQ-013 mem_ack_i outside FETCH/MEM SHALL be ignored; pc_write_o and reg_write_o SHALL never be high in the same cycle.

Reset
REQ-014 rst_i=0 SHALL immediately force IDLE, clear the MUL counter and drive every output 0, including mid-MUL and mid-memory wait.
REQ-015 After rst_i rises, the first mem_req_o SHALL assert exactly one edge later (IDLE->FETCH).

Structure
REQ-016 A shared package SHALL hold the state enum, the ALUOp codes of REQ-004, and the opcode/funct constants used by both this block and the ALU controller.
REQ-017 One sub-module, mul_cycle_counter (load, decrement, done), is natural; the rest is flat.

Verification
REQ-018 Reset release, mem_ack_i=1 always, ADD (op 0, funct 32) -> reg_write_o=1 in cycle 5 after release with reg_dst_o=1, alu_op_o=0001 in EXEC.
REQ-019 LW with FETCH ack delayed 3 cycles -> mem_req_o held 4 cycles, ir_write_o single pulse, reg_write_o with mem_to_reg_o=1 five states later.
REQ-020 BEQ zero_i=1 -> pc_write_o=1, pc_src_o=1 in EXEC; BNE zero_i=1 -> no PC write.
REQ-021 MULT, MUL_CYCLES=32 -> mul_busy_o high exactly 32 cycles, then FETCH, no reg_write_o.
REQ-022 op 63 -> illegal_o one-cycle pulse in DECODE, no writes; rst_i low mid-MUL -> all outputs 0 the same cycle.
